instr_sequencer: RTL and testbench

//  Fetch/decode/execute controller for the processor datapath (32x16-bit GPR file, ALU, flag register).

---
 rtl/instr_sequencer.sv | 160 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for the 32x16 GPR datapath.
// It fetches one instruction over a req/valid handshake and latches it into the IR.
// It then strobes exec_en for EXEC_CYCLES cycles for ALU operations, or skips execution for jumps.
// Next it advances the PC, taking a flag-conditioned jump where the instruction asks for one.
// A HALT instruction parks the sequencer until start is asserted again.
module instr_sequencer #(
    parameter int PC_W        = 8,
    parameter int EXEC_CYCLES = 1,
    parameter int RESET_PC    = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [31:0]     ir_out,
    output logic            exec_en,
    input  logic            flag_zero,
    input  logic            flag_sign,
    input  logic            flag_carry,
    input  logic            flag_ovf,
    output logic [PC_W-1:0] pc_out,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC,
        S_NEXT,
        S_HALT
    } state_t;

    localparam logic [4:0] OP_JMP  = 5'd24;
    localparam logic [4:0] OP_JC   = 5'd25;
    localparam logic [4:0] OP_JZ   = 5'd26;
    localparam logic [4:0] OP_JS   = 5'd27;
    localparam logic [4:0] OP_JV   = 5'd28;
    localparam logic [4:0] OP_HALT = 5'd31;

    // Counter reload value: the EXEC state spans EXEC_CYCLES cycles, counting down to zero.
    localparam logic [3:0]      EXEC_LAST = 4'(EXEC_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_INIT   = PC_W'(RESET_PC);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [3:0]      exec_cnt;
    logic [4:0]      oper_type;
    logic            is_jump;
    logic            jump_taken;

    assign oper_type = ir_out[31:27];
    assign is_jump   = (oper_type >= OP_JMP) && (oper_type <= OP_JV);
    assign imem_addr = pc;
    assign pc_out    = pc;

    // Jump decision from the IR opcode and the flags as they stand while in NEXT.
    always_comb begin
        // NOTE: default assignment first so no path leaves jump_taken unassigned (no latch).
        jump_taken = 1'b0;
        case (oper_type)
            OP_JMP:  jump_taken = 1'b1;
            OP_JC:   jump_taken = flag_carry;
            OP_JZ:   jump_taken = flag_zero;
            OP_JS:   jump_taken = flag_sign;
            OP_JV:   jump_taken = flag_ovf;
            default: jump_taken = 1'b0;
        endcase
    end

    // Sequencer FSM with all control outputs registered alongside the state.
    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= PC_INIT;
            ir_out   <= '0;
            exec_cnt <= '0;
            imem_req <= 1'b0;
            exec_en  <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                // The request goes out this cycle; returns are only accepted in WAIT.
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        ir_out   <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (oper_type == OP_HALT) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else if (is_jump) begin
                        state <= S_NEXT;
                    end else begin
                        state    <= S_EXEC;
                        exec_en  <= 1'b1;
                        exec_cnt <= EXEC_LAST;
                    end
                end
                S_EXEC: begin
                    if (exec_cnt == 4'd0) begin
                        exec_en <= 1'b0;
                        state   <= S_NEXT;
                    end else begin
                        exec_cnt <= exec_cnt - 4'd1;
                    end
                end
                // Flags are sampled here, after the previous instruction has executed.
                S_NEXT: begin
                    if (jump_taken) begin
                        pc <= ir_out[PC_W-1:0];
                    end else begin
                        pc <= pc + 1'b1;
                    end
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                // PC stays on the HALT instruction; a restart resumes at the following address.
                S_HALT: begin
                    if (start) begin
                        pc       <= pc + 1'b1;
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                    exec_en  <= 1'b0;
                    busy     <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer.
// Two instances are driven from one program memory: dut_a holds one execute cycle per ALU
// instruction and dut_b holds three. Expected fetch addresses and exec_en run lengths are
// queued up front, and per-instance monitors pop and compare them as the DUTs produce them.
module tb_instr_sequencer;

    logic clk;
    logic rst_n;

    logic        a_start, a_req, a_valid, a_exec, a_busy, a_halted;
    logic [7:0]  a_addr, a_pc;
    logic [31:0] a_rdata, a_ir;
    logic        a_zero, a_sign, a_carry, a_ovf;

    logic        b_start, b_req, b_valid, b_exec, b_busy, b_halted;
    logic [7:0]  b_addr, b_pc;
    logic [31:0] b_rdata, b_ir;

    logic [31:0] mem      [256];
    logic [3:0]  flag_tbl [256];   // {ovf, carry, sign, zero}
    int          lat_tbl  [256];
    logic        hold;

    int fa_q[$];
    int fb_q[$];
    int ea_q[$];
    int eb_q[$];

    int checks;
    int errors;

    instr_sequencer #(.PC_W(8), .EXEC_CYCLES(1), .RESET_PC(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start),
        .imem_req(a_req), .imem_addr(a_addr), .imem_rdata(a_rdata), .imem_valid(a_valid),
        .ir_out(a_ir), .exec_en(a_exec),
        .flag_zero(a_zero), .flag_sign(a_sign), .flag_carry(a_carry), .flag_ovf(a_ovf),
        .pc_out(a_pc), .busy(a_busy), .halted(a_halted)
    );

    instr_sequencer #(.PC_W(8), .EXEC_CYCLES(3), .RESET_PC(128)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start),
        .imem_req(b_req), .imem_addr(b_addr), .imem_rdata(b_rdata), .imem_valid(b_valid),
        .ir_out(b_ir), .exec_en(b_exec),
        .flag_zero(1'b0), .flag_sign(1'b0), .flag_carry(1'b0), .flag_ovf(1'b0),
        .pc_out(b_pc), .busy(b_busy), .halted(b_halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [15:0] isrc);
        return {op, 5'd3, 5'd4, 1'b1, isrc};
    endfunction

    // Instruction memory responders: valid rises once the request has been seen
    // for more than lat_tbl[addr] falling edges, and holds until the request drops.
    initial begin
        int a_cnt;
        int b_cnt;
        a_cnt = 0;
        b_cnt = 0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_rdata = '0;
        b_rdata = '0;
        {a_ovf, a_carry, a_sign, a_zero} = 4'b0000;
        forever begin
            @(negedge clk);
            if (a_req) begin
                a_cnt++;
                a_valid = !hold && (a_cnt > lat_tbl[a_addr]);
                a_rdata = mem[a_addr];
            end else begin
                a_cnt   = 0;
                a_valid = 1'b0;
            end
            if (b_req) begin
                b_cnt++;
                b_valid = (b_cnt > lat_tbl[b_addr]);
                b_rdata = mem[b_addr];
            end else begin
                b_cnt   = 0;
                b_valid = 1'b0;
            end
            {a_ovf, a_carry, a_sign, a_zero} = flag_tbl[a_addr];
        end
    end

    // Monitor for dut_a: each rising imem_req is a fetch, and each exec_en run is one execute.
    initial begin
        logic prev_req;
        int   run;
        prev_req = 1'b0;
        run      = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
                run      = 0;
            end else begin
                if (a_req && !prev_req) begin
                    check("a_fetch_expected", 32'(fa_q.size() != 0), 32'd1);
                    if (fa_q.size() != 0) check("a_fetch_addr", 32'(a_addr), 32'(fa_q.pop_front()));
                end
                if (a_exec) begin
                    run++;
                end else if (run != 0) begin
                    check("a_exec_expected", 32'(ea_q.size() != 0), 32'd1);
                    if (ea_q.size() != 0) check("a_exec_len", 32'(run), 32'(ea_q.pop_front()));
                    run = 0;
                end
                prev_req = a_req;
            end
        end
    end

    // Monitor for dut_b, same event definitions as for dut_a.
    initial begin
        logic prev_req;
        int   run;
        prev_req = 1'b0;
        run      = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
                run      = 0;
            end else begin
                if (b_req && !prev_req) begin
                    check("b_fetch_expected", 32'(fb_q.size() != 0), 32'd1);
                    if (fb_q.size() != 0) check("b_fetch_addr", 32'(b_addr), 32'(fb_q.pop_front()));
                end
                if (b_exec) begin
                    run++;
                end else if (run != 0) begin
                    check("b_exec_expected", 32'(eb_q.size() != 0), 32'd1);
                    if (eb_q.size() != 0) check("b_exec_len", 32'(run), 32'(eb_q.pop_front()));
                    run = 0;
                end
                prev_req = b_req;
            end
        end
    end

    task automatic wait_drain(input string name, input int budget);
        int left;
        for (int i = 0; i < budget; i++) begin
            if (fa_q.size() + fb_q.size() + ea_q.size() + eb_q.size() == 0) return;
            @(negedge clk);
        end
        left = fa_q.size() + fb_q.size() + ea_q.size() + eb_q.size();
        check(name, 32'(left), 32'd0);
    endtask

    task automatic pulse_a_start();
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    initial begin
        int req_seen;
        checks  = 0;
        errors  = 0;
        hold    = 1'b0;
        a_start = 1'b0;
        b_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]      = '0;
            flag_tbl[i] = 4'b0000;
            lat_tbl[i]  = 0;
        end
        // Program for dut_a.
        mem[8'h00] = enc(5'd2,  16'h0000);   // ADD
        mem[8'h01] = enc(5'd26, 16'h0040);   // JZ 0x40, zero set -> taken
        mem[8'h40] = enc(5'd26, 16'h0010);   // JZ 0x10, zero clear -> 0x41
        mem[8'h41] = enc(5'd27, 16'h0005);   // JS 0x05, sign set -> taken
        mem[8'h05] = enc(5'd31, 16'h0000);   // HALT
        mem[8'h06] = enc(5'd28, 16'h0020);   // JV 0x20, ovf clear -> 7
        mem[8'h07] = enc(5'd25, 16'h0030);   // JC 0x30, carry set -> taken
        mem[8'h30] = enc(5'd24, 16'h00FF);   // JMP 0xFF
        mem[8'hFF] = enc(5'd1,  16'h0012);   // MOVI, PC wraps to 0
        flag_tbl[8'h01] = 4'b0001;
        flag_tbl[8'h40] = 4'b1110;
        flag_tbl[8'h41] = 4'b0010;
        flag_tbl[8'h06] = 4'b0111;
        flag_tbl[8'h07] = 4'b0100;
        lat_tbl[8'h00]  = 3;
        lat_tbl[8'h40]  = 1;
        // Program for dut_b.
        mem[8'h80] = enc(5'd6,  16'h00F0);   // XORI
        mem[8'h81] = enc(5'd31, 16'h0000);   // HALT

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_a_req",    32'(a_req),    32'd0);
        check("rst_a_exec",   32'(a_exec),   32'd0);
        check("rst_a_pc",     32'(a_pc),     32'd0);
        check("rst_a_busy",   32'(a_busy),   32'd0);
        check("rst_a_halted", 32'(a_halted), 32'd0);
        check("rst_a_ir",     a_ir,          32'd0);
        check("rst_b_pc",     32'(b_pc),     32'h80);
        rst_n = 1'b1;

        // Reset while stalled in WAIT.
        hold = 1'b1;
        fa_q.push_back(0);
        pulse_a_start();
        repeat (2) @(negedge clk);
        check("wait_req_high", 32'(a_req),  32'd1);
        check("wait_busy",     32'(a_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req",  32'(a_req),  32'd0);
        check("midrst_exec", 32'(a_exec), 32'd0);
        check("midrst_pc",   32'(a_pc),   32'd0);
        check("midrst_busy", 32'(a_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hold  = 1'b0;

        // ADD with a late return, taken and untaken JZ, taken JS, then HALT.
        fa_q = '{0, 1, 8'h40, 8'h41, 5};
        ea_q = '{1};
        pulse_a_start();
        wait_drain("drain_run1", 300);
        for (int i = 0; i < 20 && !a_halted; i++) @(negedge clk);
        check("halt_halted", 32'(a_halted), 32'd1);
        check("halt_busy",   32'(a_busy),   32'd0);
        check("halt_pc",     32'(a_pc),     32'd5);
        check("halt_ir",     a_ir,          enc(5'd31, 16'h0000));
        req_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_req) req_seen++;
        end
        check("halt_no_req", 32'(req_seen), 32'd0);

        // Restart after HALT, untaken JV, taken JC, JMP, and wrap from 0xFF.
        fa_q = '{6, 7, 8'h30, 8'hFF, 0};
        ea_q = '{1};
        pulse_a_start();
        wait_drain("drain_run2", 300);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // dut_b: three-cycle execute, with start pulses ignored while busy.
        fb_q = '{8'h80, 8'h81};
        eb_q = '{3};
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 40 && !b_halted; i++) begin
            @(negedge clk);
            b_start = b_busy && i[0];
        end
        b_start = 1'b0;
        wait_drain("drain_run3", 50);
        check("b_halted", 32'(b_halted), 32'd1);
        check("b_pc",     32'(b_pc),     32'h81);
        repeat (5) @(negedge clk);
        check("b_stays_halted", 32'(b_halted), 32'd1);
        check("a_idle_after_rst", 32'(a_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
